// File: rtl/pmu_ahb_req_master_if.sv
// Purpose: bundles the request/response handshake and the AHB-lite master bus of
//          pmu_ahb_req_master. Signal suffixes are from the master's point of view.
// Ports:   master modport = the sequencer (drives req_ready/rsp_*/h*_o);
//          slave modport  = requester + AHB slave side (drives req_*_i/h*_i).
// Backpressure: request side is valid/ready; bus side waits on hready_i.
interface pmu_ahb_req_master_if #(
  parameter int ADDR_WIDTH = 32,
  parameter int DATA_WIDTH = 32
);
  // request / response side
  logic                  req_valid_i;
  logic                  req_ready_o;
  logic                  req_write_i;
  logic [ADDR_WIDTH-1:0] req_addr_i;
  logic [DATA_WIDTH-1:0] req_wdata_i;
  logic                  rsp_valid_o;
  logic [DATA_WIDTH-1:0] rsp_rdata_o;
  logic                  rsp_err_o;
  logic                  rsp_tmo_o;
  // AHB-lite master side
  logic                  hsel_o;
  logic [ADDR_WIDTH-1:0] haddr_o;
  logic                  hwrite_o;
  logic [1:0]            htrans_o;
  logic [2:0]            hsize_o;
  logic [2:0]            hburst_o;
  logic [DATA_WIDTH-1:0] hwdata_o;
  logic                  hready_i;
  logic [1:0]            hresp_i;
  logic [DATA_WIDTH-1:0] hrdata_i;

  modport master (
    input  req_valid_i, req_write_i, req_addr_i, req_wdata_i,
           hready_i, hresp_i, hrdata_i,
    output req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o,
           hsel_o, haddr_o, hwrite_o, htrans_o, hsize_o, hburst_o, hwdata_o
  );

  modport slave (
    output req_valid_i, req_write_i, req_addr_i, req_wdata_i,
           hready_i, hresp_i, hrdata_i,
    input  req_ready_o, rsp_valid_o, rsp_rdata_o, rsp_err_o, rsp_tmo_o,
           hsel_o, haddr_o, hwrite_o, htrans_o, hsize_o, hburst_o, hwdata_o
  );
endinterface

// File: rtl/pmu_ahb_req_master.sv
// Purpose: single-outstanding AHB-lite master turning valid/ready register requests
//          into AHB SINGLE word transfers, returning read data and error status.
// Latency: accept -> rsp_valid_o is 3 cycles minimum plus slave wait states; 1 req / 4 cycles.
// Backpressure: req_ready_o only in IDLE; bus phases stall on hready_i=0.
// Ports:   clk_i, rst_i (sync, active-high) and bus (pmu_ahb_req_master_if.master).
// Option:  define PMU_AHBM_TIMEOUT_EN to abort transfers after TIMEOUT_CYCLES wait states
//          (rsp_err_o=1, rsp_tmo_o=1); otherwise the master waits forever, rsp_tmo_o=0.
module pmu_ahb_req_master #(
  parameter int ADDR_WIDTH     = 32,
  parameter int DATA_WIDTH     = 32,
  parameter int TIMEOUT_CYCLES = 64
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  pmu_ahb_req_master_if.master  bus
);

  if (TIMEOUT_CYCLES < 2) begin : g_bad_timeout_cfg
    $error("pmu_ahb_req_master: TIMEOUT_CYCLES must be >= 2");
  end

  localparam logic [1:0] HTRANS_IDLE   = 2'b00;
  localparam logic [1:0] HTRANS_NONSEQ = 2'b10;
  localparam logic [ADDR_WIDTH-1:0] ALIGN_MASK = {{(ADDR_WIDTH-2){1'b1}}, 2'b00};

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2,
    ST_RESP = 2'd3
  } state_e;

  state_e                state_q, state_d;
  logic [ADDR_WIDTH-1:0] haddr_q, haddr_d;
  logic                  hwrite_q, hwrite_d;
  logic [DATA_WIDTH-1:0] hwdata_q, hwdata_d;
  logic [DATA_WIDTH-1:0] rdata_q, rdata_d;
  logic                  err_q, err_d;

`ifdef PMU_AHBM_TIMEOUT_EN
  localparam int CNT_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(TIMEOUT_CYCLES);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic             tmo_q, tmo_d;
  logic             waiting;
`endif

  always_comb begin
    state_d  = state_q;
    haddr_d  = haddr_q;
    hwrite_d = hwrite_q;
    hwdata_d = hwdata_q;
    rdata_d  = rdata_q;
    err_d    = err_q;
`ifdef PMU_AHBM_TIMEOUT_EN
    cnt_d    = cnt_q;
    tmo_d    = tmo_q;
`endif
    unique case (state_q)
      ST_IDLE: begin
        if (bus.req_valid_i) begin
          // Unaligned addresses are aligned down silently.
          haddr_d  = bus.req_addr_i & ALIGN_MASK;
          hwrite_d = bus.req_write_i;
          hwdata_d = bus.req_wdata_i;
          state_d  = ST_ADDR;
`ifdef PMU_AHBM_TIMEOUT_EN
          cnt_d    = '0;
`endif
        end
      end
      ST_ADDR: begin
        if (bus.hready_i) state_d = ST_DATA;
      end
      ST_DATA: begin
        // Any non-OKAY hresp ends the transfer on its first cycle; the second
        // cycle of the two-cycle error lands while we are already in RESP.
        if (bus.hresp_i != 2'b00) begin
          state_d = ST_RESP;
          err_d   = 1'b1;
          rdata_d = '0;
`ifdef PMU_AHBM_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end else if (bus.hready_i) begin
          state_d = ST_RESP;
          err_d   = 1'b0;
          rdata_d = hwrite_q ? '0 : bus.hrdata_i;
`ifdef PMU_AHBM_TIMEOUT_EN
          tmo_d   = 1'b0;
`endif
        end
      end
      ST_RESP: begin
        state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase

`ifdef PMU_AHBM_TIMEOUT_EN
    // A wait cycle is any ADDR/DATA cycle with hready_i low that is not
    // already being closed by an error response.
    if (waiting) begin
      if (cnt_q != CNT_MAX) cnt_d = cnt_q + 1'b1;
      if (cnt_q >= CNT_LAST) begin
        state_d = ST_RESP;
        err_d   = 1'b1;
        tmo_d   = 1'b1;
        rdata_d = '0;
      end
    end
`endif
  end

`ifdef PMU_AHBM_TIMEOUT_EN
  assign waiting = !bus.hready_i &&
                   ((state_q == ST_ADDR) ||
                    ((state_q == ST_DATA) && (bus.hresp_i == 2'b00)));
`endif

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q  <= ST_IDLE;
      haddr_q  <= '0;
      hwrite_q <= 1'b0;
      hwdata_q <= '0;
      rdata_q  <= '0;
      err_q    <= 1'b0;
`ifdef PMU_AHBM_TIMEOUT_EN
      cnt_q    <= '0;
      tmo_q    <= 1'b0;
`endif
    end else begin
      state_q  <= state_d;
      haddr_q  <= haddr_d;
      hwrite_q <= hwrite_d;
      hwdata_q <= hwdata_d;
      rdata_q  <= rdata_d;
      err_q    <= err_d;
`ifdef PMU_AHBM_TIMEOUT_EN
      cnt_q    <= cnt_d;
      tmo_q    <= tmo_d;
`endif
    end
  end

  // All outputs come straight from registered state; nothing is combinational
  // from the inputs, so the bus and response ports are glitch-free.
  assign bus.req_ready_o = (state_q == ST_IDLE);
  assign bus.rsp_valid_o = (state_q == ST_RESP);
  assign bus.rsp_rdata_o = rdata_q;
  assign bus.rsp_err_o   = err_q;
`ifdef PMU_AHBM_TIMEOUT_EN
  assign bus.rsp_tmo_o   = tmo_q;
`else
  assign bus.rsp_tmo_o   = 1'b0;
`endif
  assign bus.hsel_o      = (state_q == ST_ADDR);
  assign bus.htrans_o    = (state_q == ST_ADDR) ? HTRANS_NONSEQ : HTRANS_IDLE;
  assign bus.haddr_o     = haddr_q;
  assign bus.hwrite_o    = hwrite_q;
  assign bus.hsize_o     = 3'b010;
  assign bus.hburst_o    = 3'b000;
  assign bus.hwdata_o    = hwdata_q;

endmodule

// File: tb/tb_pmu_ahb_req_master.sv
// Purpose: randomized self-checking bench for pmu_ahb_req_master (default build).
// Latency: checks cycle-exact phases against a transaction-level memory model.
// Backpressure: random address/data wait states, two-cycle errors, reset mid-transfer.
module tb_pmu_ahb_req_master;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   total = 0;
  int   bad   = 0;

  always #5 clk = ~clk;

  pmu_ahb_req_master_if #(.ADDR_WIDTH(32), .DATA_WIDTH(32)) bus ();

  pmu_ahb_req_master #(
    .ADDR_WIDTH(32), .DATA_WIDTH(32), .TIMEOUT_CYCLES(64)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  // Reference memory: word-addressed contents of the slave at the PMU base.
  logic [31:0] mem [logic [31:0]];

  function automatic logic [31:0] mem_rd(input logic [31:0] a);
    if (mem.exists(a)) return mem[a];
    return a ^ 32'h5A5A_0F0F;
  endfunction

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic check_reset_outputs(input string pfx);
    check({pfx, "_req_ready"}, bus.req_ready_o, 1);
    check({pfx, "_rsp_valid"}, bus.rsp_valid_o, 0);
    check({pfx, "_rsp_err"},   bus.rsp_err_o,   0);
    check({pfx, "_rsp_tmo"},   bus.rsp_tmo_o,   0);
    check({pfx, "_rsp_rdata"}, bus.rsp_rdata_o, 0);
    check({pfx, "_hsel"},      bus.hsel_o,      0);
    check({pfx, "_htrans"},    bus.htrans_o,    0);
    check({pfx, "_haddr"},     bus.haddr_o,     0);
    check({pfx, "_hwdata"},    bus.hwdata_o,    0);
    check({pfx, "_hwrite"},    bus.hwrite_o,    0);
  endtask

  // One request, driven and checked at falling edges. Entered and left at the
  // falling edge of an IDLE cycle. aw/dw = address/data-phase wait states;
  // ef = slave answers with a two-cycle ERROR.
  task automatic do_txn(input logic wr, input logic [31:0] addr, input logic [31:0] wd,
                        input int aw, input int dw, input logic ef);
    logic [31:0] al;
    logic [31:0] seen_addr;
    logic [31:0] exp_rd;
    al = addr & 32'hFFFF_FFFC;
    seen_addr = '0;
    check("idle_ready", bus.req_ready_o, 1);
    bus.req_valid_i = 1'b1;
    bus.req_write_i = wr;
    bus.req_addr_i  = addr;
    bus.req_wdata_i = wd;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.req_write_i = $urandom_range(0, 1);
    bus.req_addr_i  = $urandom;
    bus.req_wdata_i = $urandom;
    // address phase
    for (int i = 0; i <= aw; i++) begin
      bus.hready_i = (i == aw);
      bus.hresp_i  = 2'b00;
      bus.hrdata_i = $urandom;
      check("addr_hsel",   bus.hsel_o,      1);
      check("addr_htrans", bus.htrans_o,    2'b10);
      check("addr_haddr",  bus.haddr_o,     al);
      check("addr_hwrite", bus.hwrite_o,    wr);
      check("addr_hsize",  bus.hsize_o,     3'b010);
      check("addr_hburst", bus.hburst_o,    3'b000);
      check("addr_ready",  bus.req_ready_o, 0);
      check("addr_rspv",   bus.rsp_valid_o, 0);
      seen_addr = bus.haddr_o;
      @(negedge clk);
    end
    // data phase wait states
    for (int i = 0; i < dw; i++) begin
      bus.hready_i = 1'b0;
      bus.hresp_i  = 2'b00;
      bus.hrdata_i = $urandom;
      check("data_htrans", bus.htrans_o,    2'b00);
      check("data_hsel",   bus.hsel_o,      0);
      check("data_rspv",   bus.rsp_valid_o, 0);
      if (wr) check("data_hwdata_wait", bus.hwdata_o, wd);
      @(negedge clk);
    end
    check("data_last_htrans", bus.htrans_o,    2'b00);
    check("data_last_rspv",   bus.rsp_valid_o, 0);
    if (wr) check("data_last_hwdata", bus.hwdata_o, wd);
    if (ef) begin
      bus.hready_i = 1'b0;
      bus.hresp_i  = ($urandom_range(0, 3) == 0) ? 2'b11 : 2'b01;
      bus.hrdata_i = $urandom;
      exp_rd = '0;
      @(negedge clk);
      bus.hready_i = 1'b1;   // second cycle of the error response
    end else begin
      bus.hready_i = 1'b1;
      bus.hresp_i  = 2'b00;
      bus.hrdata_i = wr ? $urandom : mem_rd(seen_addr);
      exp_rd = wr ? 32'h0 : mem_rd(al);
      if (wr) mem[al] = wd;
      @(negedge clk);
      bus.hresp_i  = 2'b00;
    end
    check("resp_valid", bus.rsp_valid_o, 1);
    check("resp_rdata", bus.rsp_rdata_o, exp_rd);
    check("resp_err",   bus.rsp_err_o,   ef);
    check("resp_tmo",   bus.rsp_tmo_o,   0);
    check("resp_ready", bus.req_ready_o, 0);
    check("resp_hsel",  bus.hsel_o,      0);
    @(negedge clk);
    bus.hresp_i  = 2'b00;
    bus.hready_i = 1'b1;
    check("post_valid", bus.rsp_valid_o, 0);
    check("post_rdata_hold", bus.rsp_rdata_o, exp_rd);
    check("post_err_hold",   bus.rsp_err_o,   ef);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog time limit reached");
    $display("test done: total=%0d bad=%0d", total, bad + 1);
    $fatal(1, "watchdog");
  end

  initial begin
    bus.req_valid_i = 1'b0;
    bus.req_write_i = 1'b0;
    bus.req_addr_i  = '0;
    bus.req_wdata_i = '0;
    bus.hready_i    = 1'b1;
    bus.hresp_i     = 2'b00;
    bus.hrdata_i    = '0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    check_reset_outputs("rst");
    rst = 1'b0;
    @(negedge clk);
    check("rst_release_ready", bus.req_ready_o, 1);

    // directed cases
    do_txn(1'b1, 32'h8010_0000, 32'h0000_0002, 0, 0, 1'b0);
    do_txn(1'b1, 32'h8010_00ac, 32'hcafe_cafe, 0, 0, 1'b0);
    do_txn(1'b0, 32'h8010_00ac, 32'h0,         0, 0, 1'b0);
    do_txn(1'b1, 32'h8010_0010, 32'h1234_5678, 0, 5, 1'b0);
    do_txn(1'b0, 32'h8010_0ff0, 32'h0,         0, 0, 1'b1);
    do_txn(1'b0, 32'h8010_0010, 32'h0,         2, 1, 1'b0);
    do_txn(1'b0, 32'h8010_00ae, 32'h0,         1, 0, 1'b0);

    // reset pulsed while in the data phase
    bus.req_valid_i = 1'b1;
    bus.req_write_i = 1'b1;
    bus.req_addr_i  = 32'h8010_0020;
    bus.req_wdata_i = 32'hdead_beef;
    @(negedge clk);
    bus.req_valid_i = 1'b0;
    bus.hready_i    = 1'b1;
    @(negedge clk);
    check("rstdata_in_data", bus.htrans_o, 2'b00);
    bus.hready_i = 1'b0;
    rst = 1'b1;
    @(negedge clk);
    check_reset_outputs("rstmid");
    rst = 1'b0;
    bus.hready_i = 1'b1;
    @(negedge clk);
    check("rstmid_no_rsp", bus.rsp_valid_o, 0);
    check("rstmid_ready",  bus.req_ready_o, 1);
    do_txn(1'b0, 32'h8010_0020, 32'h0, 0, 0, 1'b0);

    // randomized traffic, with back-to-back and gapped requests
    for (int n = 0; n < 60; n++) begin
      logic        wr;
      logic [31:0] a;
      wr = ($urandom_range(0, 1) == 1);
      a  = 32'h8010_0000 + ($urandom_range(0, 15) * 4) + $urandom_range(0, 3);
      do_txn(wr, a, $urandom, $urandom_range(0, 2), $urandom_range(0, 4),
             ($urandom_range(0, 7) == 0));
      for (int g = $urandom_range(0, 2); g > 0; g--) begin
        check("gap_ready", bus.req_ready_o, 1);
        check("gap_rspv",  bus.rsp_valid_o, 0);
        @(negedge clk);
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
